// File: rtl/ddr_app_master.sv
// Single-burst initiator for the DDR controller app interface: one app command per 512-bit beat.
// Optional protocol checker (sticky err) is enabled by defining DDR_APP_MASTER_CHK_EN.
module ddr_app_master #(
    parameter int APP_DATA_WIDTH  = 512,
    parameter int APP_ADDR_WIDTH  = 30,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                      clk_ddr,
    input  logic                      reset,
    input  logic                      init_done,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APP_ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]      req_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [APP_DATA_WIDTH-1:0] wr_data,
    output logic                      rd_valid,
    output logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic                      done,
    output logic                      err,
    input  logic                      app_rdy,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [APP_ADDR_WIDTH-1:0] app_addr,
    input  logic                      app_wdf_rdy,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    input  logic                      app_rd_data_valid,
    input  logic                      app_rd_data_end,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data
);

    localparam int                        OUT_W     = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [2:0]                CMD_WRITE = 3'h0;
    localparam logic [2:0]                CMD_READ  = 3'h1;
    localparam logic [APP_ADDR_WIDTH-1:0] ADDR_STEP = APP_ADDR_WIDTH'(8);
    localparam logic [OUT_W-1:0]          OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, FIN} state_t;

    state_t                    state_q, state_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      cmd_cnt_q, cmd_cnt_d;
    logic [LEN_WIDTH-1:0]      wdf_cnt_q, wdf_cnt_d;
    logic [OUT_W-1:0]          outstanding_q, outstanding_d;
    logic                      app_en_q, app_en_d;
    logic [2:0]                app_cmd_q, app_cmd_d;
    logic [APP_ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [APP_DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic in_write, in_read, req_fire, cmd_acc, wdf_open, wdf_acc, rd_ret;
    logic unused_rd_end;

    always_ff @(posedge clk_ddr) begin
        if (reset) state_q <= INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_done) state_d = IDLE;
            IDLE:    if (req_fire) state_d = (req_len == '0) ? FIN : (req_write ? WRITE : READ);
            WRITE:   if (cmd_cnt_d == len_q && wdf_cnt_d == len_q) state_d = FIN;
            READ:    if (cmd_cnt_q == len_q && outstanding_q == '0 && !app_rd_data_valid) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        in_write  = 1'b0;
        in_read   = 1'b0;
        case (state_q)
            IDLE:    req_ready = 1'b1;
            WRITE:   in_write  = 1'b1;
            READ:    in_read   = 1'b1;
            FIN:     done      = 1'b1;
            default: ;
        endcase
    end

    assign req_fire      = req_valid & req_ready;
    assign cmd_acc       = app_en_q & app_rdy;
    assign wdf_open      = in_write & (wdf_cnt_q < len_q);
    assign app_wdf_wren  = wdf_open & wr_valid;
    assign app_wdf_end   = app_wdf_wren;
    assign wr_ready      = wdf_open & app_wdf_rdy;
    assign app_wdf_data  = in_write ? wr_data : '0;
    assign wdf_acc       = app_wdf_wren & app_wdf_rdy;
    assign rd_ret        = in_read & app_rd_data_valid;
    assign app_en        = app_en_q;
    assign app_cmd       = app_cmd_q;
    assign app_addr      = app_addr_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign unused_rd_end = app_rd_data_end;

    // A pending command stays asserted until accepted; a new one is raised only when beats remain
    // and, for reads, the outstanding window has room.
    always_comb begin
        len_d         = len_q;
        cmd_cnt_d     = cmd_cnt_q;
        wdf_cnt_d     = wdf_cnt_q;
        outstanding_d = outstanding_q;
        app_en_d      = 1'b0;
        app_cmd_d     = app_cmd_q;
        app_addr_d    = app_addr_q;
        rd_valid_d    = rd_ret;
        rd_data_d     = rd_ret ? app_rd_data : rd_data_q;
        if (req_fire) begin
            len_d         = req_len;
            cmd_cnt_d     = '0;
            wdf_cnt_d     = '0;
            outstanding_d = '0;
            app_cmd_d     = req_write ? CMD_WRITE : CMD_READ;
            app_addr_d    = req_addr;
            app_en_d      = (req_len != '0);
        end else if (in_write || in_read) begin
            if (cmd_acc) begin
                cmd_cnt_d  = cmd_cnt_q + LEN_WIDTH'(1);
                app_addr_d = app_addr_q + ADDR_STEP;
            end
            if (wdf_acc) wdf_cnt_d = wdf_cnt_q + LEN_WIDTH'(1);
            case ({cmd_acc & in_read, rd_ret})
                2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
                2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - OUT_W'(1);
                default: ;
            endcase
            app_en_d = (app_en_q & ~app_rdy) |
                       ((cmd_cnt_d < len_q) & (in_write | (outstanding_d < OUT_MAX)));
        end
    end

    always_ff @(posedge clk_ddr) begin
        if (reset) begin
            len_q         <= '0;
            cmd_cnt_q     <= '0;
            wdf_cnt_q     <= '0;
            outstanding_q <= '0;
            app_en_q      <= 1'b0;
            app_cmd_q     <= 3'h0;
            app_addr_q    <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            len_q         <= len_d;
            cmd_cnt_q     <= cmd_cnt_d;
            wdf_cnt_q     <= wdf_cnt_d;
            outstanding_q <= outstanding_d;
            app_en_q      <= app_en_d;
            app_cmd_q     <= app_cmd_d;
            app_addr_q    <= app_addr_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

`ifdef DDR_APP_MASTER_CHK_EN
    localparam logic [APP_ADDR_WIDTH-1:0] WRAP_START = {APP_ADDR_WIDTH{1'b1}} - APP_ADDR_WIDTH'(7);

    logic err_q, err_d, addr_wraps;

    // Only a wrap that a later command of the same burst would land on counts as an error.
    assign addr_wraps = cmd_acc & (app_addr_q >= WRAP_START) & (cmd_cnt_d < len_q);

    always_comb begin
        err_d = err_q
              | (app_rd_data_valid & (outstanding_q == '0) & ~(cmd_acc & in_read))
              | (req_fire & (req_len == '0))
              | addr_wraps;
    end

    always_ff @(posedge clk_ddr) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_app_master.sv
// Scoreboard bench for ddr_app_master: random controller readiness, a small DDR model in the bench,
// and expected commands / write beats / read beats queued at stimulus time.
module tb_ddr_app_master;

    localparam int DW      = 512;
    localparam int AW      = 30;
    localparam int LW      = 16;
    localparam int MO      = 16;
    localparam int PCT_RDY = 70;
`ifdef DDR_APP_MASTER_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
    } CmdExp;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } RdRet;

    logic          clk_ddr = 1'b0;
    logic          reset = 1'b1;
    logic          initDone = 1'b0;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic          reqWrite = 1'b0;
    logic [AW-1:0] reqAddr = '0;
    logic [LW-1:0] reqLen = '0;
    logic          wrValid = 1'b0;
    logic          wrReady;
    logic [DW-1:0] wrData = '0;
    logic          rdValid;
    logic [DW-1:0] rdData;
    logic          done;
    logic          err;
    logic          appRdy = 1'b0;
    logic          appEn;
    logic [2:0]    appCmd;
    logic [AW-1:0] appAddr;
    logic          appWdfRdy = 1'b0;
    logic          appWdfWren;
    logic          appWdfEnd;
    logic [DW-1:0] appWdfData;
    logic          appRdDataValid = 1'b0;
    logic          appRdDataEnd = 1'b0;
    logic [DW-1:0] appRdData = '0;

    ddr_app_master #(
        .APP_DATA_WIDTH (DW),
        .APP_ADDR_WIDTH (AW),
        .LEN_WIDTH      (LW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_ddr          (clk_ddr),
        .reset            (reset),
        .init_done        (initDone),
        .req_valid        (reqValid),
        .req_ready        (reqReady),
        .req_write        (reqWrite),
        .req_addr         (reqAddr),
        .req_len          (reqLen),
        .wr_valid         (wrValid),
        .wr_ready         (wrReady),
        .wr_data          (wrData),
        .rd_valid         (rdValid),
        .rd_data          (rdData),
        .done             (done),
        .err              (err),
        .app_rdy          (appRdy),
        .app_en           (appEn),
        .app_cmd          (appCmd),
        .app_addr         (appAddr),
        .app_wdf_rdy      (appWdfRdy),
        .app_wdf_wren     (appWdfWren),
        .app_wdf_end      (appWdfEnd),
        .app_wdf_data     (appWdfData),
        .app_rd_data_valid(appRdDataValid),
        .app_rd_data_end  (appRdDataEnd),
        .app_rd_data      (appRdData)
    );

    always #5 clk_ddr = ~clk_ddr;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int doneCount = 0, doneCycle = 0, hsCycle = 0, lastAccCycle = 0, lastRdCycle = 0;
    int appEnCycles = 0, cmdAccCount = 0, rdValidCount = 0, lateRetCount = 0;
    int tbOut = 0, maxOut = 0, lastDue = 0;
    int delayMin = 12, delayMax = 20;
    bit forceRdyLow = 1'b0;

    CmdExp         expCmdQ[$];
    logic [DW-1:0] expWdfQ[$];
    logic [DW-1:0] expRdQ[$];
    logic [DW-1:0] wrSrcQ[$];
    logic [DW-1:0] refMem[logic [AW-1:0]];
    logic [DW-1:0] ddrMem[logic [AW-1:0]];
    logic [AW-1:0] ddrWrAddrQ[$];
    logic [DW-1:0] ddrWrDataQ[$];
    RdRet          retQ[$];

    // Contents of never-written DDR locations: the address repeated across the beat.
    function automatic logic [DW-1:0] fillPattern(input logic [AW-1:0] a);
        return {16{a, 2'b01}};
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(posedge clk_ddr) cycle++;

    // Controller-side driver: random readiness, in-order read returns, and the write-data source.
    always @(posedge clk_ddr) begin
        #1;
        appRdy    = forceRdyLow ? 1'b0 : ($urandom_range(0, 99) < PCT_RDY);
        appWdfRdy = ($urandom_range(0, 99) < PCT_RDY);
        if (retQ.size() > 0 && retQ[0].due <= cycle) begin
            appRdDataValid = 1'b1;
            appRdDataEnd   = 1'b1;
            appRdData      = retQ.pop_front().data;
        end else begin
            appRdDataValid = 1'b0;
            appRdDataEnd   = 1'b0;
        end
        if (wrSrcQ.size() > 0 && $urandom_range(0, 99) < 80) begin
            wrValid = 1'b1;
            wrData  = wrSrcQ[0];
        end else begin
            wrValid = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a command, write beat or read beat.
    always @(negedge clk_ddr) begin : monitor
        CmdExp e;
        RdRet  r;
        int    d;
        if (!reset) begin
            if (appEn) appEnCycles++;
            if (reqValid && reqReady) hsCycle = cycle;
            if (appEn && appRdy) begin
                cmdAccCount++;
                lastAccCycle = cycle;
                if (expCmdQ.size() == 0) begin
                    checkOutput("cmd_unexpected", {appCmd, appAddr}, '0);
                end else begin
                    e = expCmdQ.pop_front();
                    checkOutput("app_cmd", appCmd, e.cmd);
                    checkOutput("app_addr", appAddr, e.addr);
                end
                if (appCmd == 3'h1) begin
                    d = int'($urandom_range(delayMin, delayMax));
                    r.due  = (cycle + d > lastDue + 1) ? cycle + d : lastDue + 1;
                    r.data = ddrMem.exists(appAddr) ? ddrMem[appAddr] : fillPattern(appAddr);
                    lastDue = r.due;
                    retQ.push_back(r);
                    tbOut++;
                    if (tbOut > maxOut) maxOut = tbOut;
                end else begin
                    ddrWrAddrQ.push_back(appAddr);
                end
            end
            if (appWdfWren && appWdfRdy) begin
                lastAccCycle = cycle;
                checkOutput("wdf_end", appWdfEnd, 1);
                if (expWdfQ.size() == 0) checkOutput("wdf_unexpected", appWdfData, '0);
                else checkOutput("wdf_data", appWdfData, expWdfQ.pop_front());
                ddrWrDataQ.push_back(appWdfData);
                if (wrSrcQ.size() > 0) void'(wrSrcQ.pop_front());
            end
            while (ddrWrAddrQ.size() > 0 && ddrWrDataQ.size() > 0)
                ddrMem[ddrWrAddrQ.pop_front()] = ddrWrDataQ.pop_front();
            if (appRdDataValid) begin
                tbOut--;
                lateRetCount++;
            end
            if (rdValid) begin
                rdValidCount++;
                lastRdCycle = cycle;
                if (expRdQ.size() == 0) checkOutput("rd_unexpected", rdData, '0);
                else checkOutput("rd_data", rdData, expRdQ.pop_front());
            end
            if (done) begin
                doneCount++;
                doneCycle = cycle;
            end
        end
    end

    // Queue the expected behaviour of one burst, then perform the request handshake.
    task automatic applyStimulus(input bit write, input logic [AW-1:0] addr, input int len, input bit seqData);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            n;
        doneCount   = 0;
        appEnCycles = 0;
        cmdAccCount = 0;
        tbOut       = 0;
        maxOut      = 0;
        for (int i = 0; i < len; i++) begin
            a = addr + AW'(8 * i);
            expCmdQ.push_back({write ? 3'h0 : 3'h1, a});
            if (write) begin
                if (seqData) d = DW'(i);
                else for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
                expWdfQ.push_back(d);
                wrSrcQ.push_back(d);
                refMem[a] = d;
            end else begin
                expRdQ.push_back(refMem.exists(a) ? refMem[a] : fillPattern(a));
            end
        end
        @(posedge clk_ddr);
        #1;
        reqValid = 1'b1;
        reqWrite = write;
        reqAddr  = addr;
        reqLen   = LW'(len);
        n = 0;
        do begin
            @(negedge clk_ddr);
            n++;
        end while (!reqReady && n < 50);
        if (!reqReady) checkOutput("req_ready_timeout", reqReady, 1);
        @(posedge clk_ddr);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (doneCount == 0 && n < budget) begin
            @(negedge clk_ddr);
            n++;
        end
        if (doneCount == 0) begin
            checkOutput({tag, "_done_timeout"}, doneCount, 1);
        end else begin
            repeat (3) @(negedge clk_ddr);
            checkOutput({tag, "_done_pulses"}, doneCount, 1);
        end
    endtask

    task automatic checkQueuesEmpty(input string tag);
        checkOutput({tag, "_cmds_left"}, expCmdQ.size(), 0);
        checkOutput({tag, "_wdf_left"}, expWdfQ.size(), 0);
        checkOutput({tag, "_rd_left"}, expRdQ.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, reqReady, 0);
        checkOutput({tag, "_wr_ready"}, wrReady, 0);
        checkOutput({tag, "_rd_valid"}, rdValid, 0);
        checkOutput({tag, "_rd_data"}, rdData, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_app_en"}, appEn, 0);
        checkOutput({tag, "_app_cmd"}, appCmd, 0);
        checkOutput({tag, "_app_addr"}, appAddr, 0);
        checkOutput({tag, "_wdf_wren"}, appWdfWren, 0);
        checkOutput({tag, "_wdf_end"}, appWdfEnd, 0);
        checkOutput({tag, "_wdf_data"}, appWdfData, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : mainSeq
        int  n;
        bit  timingOk;

        repeat (2) @(posedge clk_ddr);
        @(negedge clk_ddr);
        checkResetOutputs("reset");
        @(posedge clk_ddr);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk_ddr);
        checkOutput("init_hold_req_ready", reqReady, 0);
        @(posedge clk_ddr);
        #1 initDone = 1'b1;
        repeat (2) @(negedge clk_ddr);
        checkOutput("idle_req_ready", reqReady, 1);

        $display("[TB] write 4 beats at 0x100");
        applyStimulus(1'b1, 30'h100, 4, 1'b1);
        waitDone("wr4", 2000);
        checkOutput("wr4_done_timing", doneCycle, lastAccCycle + 1);
        checkQueuesEmpty("wr4");

        $display("[TB] read back 4 beats at 0x100");
        applyStimulus(1'b0, 30'h100, 4, 1'b0);
        waitDone("rd4", 2000);
        checkOutput("rd4_done_timing", doneCycle, lastRdCycle + 1);
        checkQueuesEmpty("rd4");

        $display("[TB] read 40 beats with 100-cycle return delay");
        delayMin = 100;
        delayMax = 100;
        applyStimulus(1'b0, 30'h4000, 40, 1'b0);
        waitDone("rd40", 5000);
        checkOutput("rd40_max_outstanding", maxOut, MO);
        checkOutput("rd40_done_timing", doneCycle, lastRdCycle + 1);
        checkQueuesEmpty("rd40");
        checkOutput("rd40_err", err, 0);

        $display("[TB] write 2 beats across the address wrap");
        delayMin = 12;
        delayMax = 20;
        applyStimulus(1'b1, 30'h3FFF_FFF8, 2, 1'b0);
        waitDone("wrap", 2000);
        checkOutput("wrap_done_timing", doneCycle, lastAccCycle + 1);
        checkQueuesEmpty("wrap");
        checkOutput("wrap_err", err, CHK_EN);

        $display("[TB] reset after 3 of 8 read commands");
        delayMin = 30;
        delayMax = 30;
        applyStimulus(1'b0, 30'h100, 8, 1'b0);
        n = 0;
        while (n < 500) begin
            @(posedge clk_ddr);
            if (cmdAccCount >= 3) break;
            n++;
        end
        checkOutput("midreset_cmds_before_reset", cmdAccCount, 3);
        forceRdyLow = 1'b1;
        #2 reset = 1'b1;
        expCmdQ.delete();
        expRdQ.delete();
        @(posedge clk_ddr);
        #1 reset = 1'b0;
        forceRdyLow  = 1'b0;
        tbOut        = 0;
        rdValidCount = 0;
        lateRetCount = 0;
        @(negedge clk_ddr);
        checkResetOutputs("midreset");
        n = 0;
        while (retQ.size() > 0 && n < 300) begin
            @(negedge clk_ddr);
            n++;
        end
        repeat (5) @(negedge clk_ddr);
        checkOutput("midreset_late_returns", lateRetCount, 3);
        checkOutput("midreset_late_rd_valid", rdValidCount, 0);
        delayMin = 12;
        delayMax = 20;
        applyStimulus(1'b0, 30'h108, 1, 1'b0);
        waitDone("post_reset_rd1", 2000);
        checkOutput("post_reset_rd1_done_timing", doneCycle, lastRdCycle + 1);
        checkQueuesEmpty("post_reset_rd1");

        $display("[TB] zero-length request");
        applyStimulus(1'b0, 30'h200, 0, 1'b0);
        waitDone("len0", 200);
        timingOk = (doneCycle == hsCycle + 1) || (doneCycle == hsCycle + 2);
        checkOutput("len0_done_timing", timingOk, 1);
        checkOutput("len0_app_en_cycles", appEnCycles, 0);
        checkOutput("len0_err", err, CHK_EN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
